// File: rtl/disasm_trace_sched.sv
// disasm_trace_sched: arbitrates instruction-trace entries from the IF tap (port 0)
// and the WB tap (port 1) onto the single shared BINARY_TO_MIPS disassembler.
// Each tap feeds its own FIFO. A round-robin arbiter fills one registered
// presentation stage, which holds its outputs until the trace printer accepts them.
// Optional build macro: TRACE_NOP_FILTER_EN. When it is defined, nop words
// (32'h00000000) are accepted but discarded, and drop_cnt counts them.
module disasm_trace_sched #(
   parameter int DEPTH = 4,
   parameter int SEQ_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in0_valid,
   output logic             in0_ready,
   input  logic [31:0]      in0_inst,
   input  logic [31:0]      in0_pc,
   input  logic             in1_valid,
   output logic             in1_ready,
   input  logic [31:0]      in1_inst,
   input  logic [31:0]      in1_pc,
   output logic             dis_valid,
   input  logic             dis_ready,
   output logic [31:0]      dis_inst,
   output logic [31:0]      dis_pc,
   output logic             dis_src,
   output logic [SEQ_W-1:0] dis_seq,
   output logic [15:0]      drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]    PTR_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [SEQ_W-1:0] SEQ_ONE = {{(SEQ_W-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE, PRESENT} pstate_t;

   // Saturating add used by the nop drop counter.
   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] n);
      logic [16:0] s;
      s = {1'b0, a} + {15'b0, n};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   logic [31:0] mem_inst [2][DEPTH];
   logic [31:0] mem_pc   [2][DEPTH];
   logic [AW:0] wr_ptr   [2];
   logic [AW:0] rd_ptr   [2];

   logic [31:0] in_inst  [2];
   logic [31:0] in_pc    [2];
   logic [1:0]  in_valid;
   logic [1:0]  empty;
   logic [1:0]  full;
   logic [1:0]  push;
   logic [1:0]  is_nop;
   logic [1:0]  store;
   logic [1:0]  pop;
   logic        load;
   logic        grant;
   logic        last_grant;
   logic [31:0] head_inst;
   logic [31:0] head_pc;
   logic [SEQ_W-1:0] seq_cnt;
   pstate_t     state;

   // Fold both taps into indexed form and derive FIFO status, arbitration and load.
   always_comb begin
      in_valid   = {in1_valid, in0_valid};
      in_inst[0] = in0_inst;
      in_inst[1] = in1_inst;
      in_pc[0]   = in0_pc;
      in_pc[1]   = in1_pc;
      for (int p = 0; p < 2; p++) begin
         empty[p]  = (wr_ptr[p] == rd_ptr[p]);
         full[p]   = (wr_ptr[p][AW] != rd_ptr[p][AW]) &&
                     (wr_ptr[p][AW-1:0] == rd_ptr[p][AW-1:0]);
         push[p]   = in_valid[p] && !full[p];
`ifdef TRACE_NOP_FILTER_EN
         is_nop[p] = (in_inst[p] == 32'h0000_0000);
`else
         is_nop[p] = 1'b0;
`endif
         store[p]  = push[p] && !is_nop[p];
      end
      load = (!dis_valid || dis_ready) && (!empty[0] || !empty[1]);
      if (empty[0])
         grant = 1'b1;
      else if (empty[1])
         grant = 1'b0;
      else
         grant = !last_grant;
      pop[0]    = load && !grant;
      pop[1]    = load && grant;
      head_inst = mem_inst[grant][rd_ptr[grant][AW-1:0]];
      head_pc   = mem_pc[grant][rd_ptr[grant][AW-1:0]];
   end

   assign in0_ready = !full[0];
   assign in1_ready = !full[1];
   assign dis_valid = (state == PRESENT);

   // Tap FIFOs: write on accepted non-nop push, advance read on grant; flush empties both.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int p = 0; p < 2; p++) begin
            wr_ptr[p] <= '0;
            rd_ptr[p] <= '0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (store[p]) begin
               mem_inst[p][wr_ptr[p][AW-1:0]] <= in_inst[p];
               mem_pc[p][wr_ptr[p][AW-1:0]]   <= in_pc[p];
               wr_ptr[p] <= wr_ptr[p] + PTR_ONE;
            end
            if (pop[p])
               rd_ptr[p] <= rd_ptr[p] + PTR_ONE;
         end
      end
   end

   // Presentation stage FSM: load the granted head, hold while the printer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         dis_inst   <= '0;
         dis_pc     <= '0;
         dis_src    <= 1'b0;
         dis_seq    <= '0;
         seq_cnt    <= '0;
         last_grant <= 1'b1;
      end else if (flush) begin
         state <= IDLE;
      end else if (load) begin
         state      <= PRESENT;
         dis_inst   <= head_inst;
         dis_pc     <= head_pc;
         dis_src    <= grant;
         dis_seq    <= seq_cnt;
         seq_cnt    <= seq_cnt + SEQ_ONE;
         last_grant <= grant;
      end else if (dis_ready) begin
         state <= IDLE;
      end
   end

`ifdef TRACE_NOP_FILTER_EN
   logic [1:0] nop_hits;
   assign nop_hits = {1'b0, push[0] && is_nop[0]} + {1'b0, push[1] && is_nop[1]};

   // Count nop pushes that were accepted and discarded; flushed pushes are not counted.
   always_ff @(posedge clk) begin
      if (rst)
         drop_cnt <= '0;
      else if (!flush)
         drop_cnt <= sat_add(drop_cnt, nop_hits);
   end
`else
   assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_disasm_trace_sched.sv
// Directed bench for disasm_trace_sched: a queue-based model of the scheduler is
// compared against the DUT every cycle, and literal expectations pin the model.
module tb_disasm_trace_sched;
   localparam int DEPTH = 4;
   localparam int SEQ_W = 16;
`ifdef TRACE_NOP_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1, flush = 1'b0;
   logic in0_valid = 1'b0, in1_valid = 1'b0, dis_ready = 1'b0;
   logic [31:0] in0_inst = '0, in0_pc = '0, in1_inst = '0, in1_pc = '0;
   logic in0_ready, in1_ready, dis_valid, dis_src;
   logic [31:0] dis_inst, dis_pc;
   logic [SEQ_W-1:0] dis_seq;
   logic [15:0] drop_cnt;

   disasm_trace_sched #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_inst(in0_inst), .in0_pc(in0_pc),
      .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_inst(in1_inst), .in1_pc(in1_pc),
      .dis_valid(dis_valid), .dis_ready(dis_ready), .dis_inst(dis_inst), .dis_pc(dis_pc),
      .dis_src(dis_src), .dis_seq(dis_seq), .drop_cnt(drop_cnt)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;

   ent_t        mq0[$];
   ent_t        mq1[$];
   logic        m_valid, m_src, m_lg;
   logic [31:0] m_inst, m_pc;
   logic [15:0] m_seq, m_cnt, m_drop;
   bit          m_live = 0;

   always @(posedge clk) begin
      bit   r0, r1, ld, g;
      ent_t e;
      if (rst) begin
         mq0.delete(); mq1.delete();
         m_valid = 0; m_inst = 0; m_pc = 0; m_src = 0; m_seq = 0;
         m_cnt = 0; m_lg = 1; m_drop = 0; m_live = 1;
      end else if (flush) begin
         mq0.delete(); mq1.delete();
         m_valid = 0;
      end else begin
         r0 = (mq0.size() < DEPTH);
         r1 = (mq1.size() < DEPTH);
         ld = (!m_valid || dis_ready) && (mq0.size() != 0 || mq1.size() != 0);
         if (ld) begin
            if (mq0.size() == 0) g = 1;
            else if (mq1.size() == 0) g = 0;
            else g = !m_lg;
            e = g ? mq1.pop_front() : mq0.pop_front();
            m_valid = 1; m_inst = e.inst; m_pc = e.pc; m_src = g;
            m_seq = m_cnt; m_cnt = m_cnt + 16'd1; m_lg = g;
         end else if (dis_ready) begin
            m_valid = 0;
         end
         if (in0_valid && r0) begin
            if (FILT && in0_inst == 32'h0) begin
               if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end else begin
               e.inst = in0_inst; e.pc = in0_pc; mq0.push_back(e);
            end
         end
         if (in1_valid && r1) begin
            if (FILT && in1_inst == 32'h0) begin
               if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end else begin
               e.inst = in1_inst; e.pc = in1_pc; mq1.push_back(e);
            end
         end
      end
   end

   // Per-cycle comparison against the model, mid-cycle.
   always @(negedge clk) begin
      if (m_live) begin
         check("dis_valid", dis_valid, m_valid);
         check("dis_inst", dis_inst, m_inst);
         check("dis_pc", dis_pc, m_pc);
         check("dis_src", dis_src, m_src);
         check("dis_seq", dis_seq, m_seq);
         check("in0_ready", in0_ready, mq0.size() < DEPTH);
         check("in1_ready", in1_ready, mq1.size() < DEPTH);
         check("drop_cnt", drop_cnt, m_drop);
      end
   end

   // Log of entries handed to the printer.
   logic [31:0] log_inst[$];
   logic        log_src[$];
   logic [15:0] log_seq[$];

   always @(negedge clk) begin
      if (!rst && dis_valid && dis_ready) begin
         log_inst.push_back(dis_inst);
         log_src.push_back(dis_src);
         log_seq.push_back(dis_seq);
      end
   end

   task automatic clear_log();
      log_inst.delete(); log_src.delete(); log_seq.delete();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      logic [31:0] exp_inst [6];
      logic [31:0] held;

      // 1: reset
      rst = 1; step(); step();
      rst = 0; step(); step();
      check("t1_valid", dis_valid, 1'b0);
      check("t1_inst", dis_inst, 32'h0);
      check("t1_pc", dis_pc, 32'h0);
      check("t1_seq", dis_seq, 16'h0);
      check("t1_rdy0", in0_ready, 1'b1);
      check("t1_rdy1", in1_ready, 1'b1);
      check("t1_drop", drop_cnt, 16'h0);

      // 2: single push on port 0
      dis_ready = 1;
      in0_valid = 1; in0_inst = 32'h00084080; in0_pc = 32'h00400000;
      step();
      in0_valid = 0;
      check("t2_nobypass", dis_valid, 1'b0);
      step();
      check("t2_valid", dis_valid, 1'b1);
      check("t2_inst", dis_inst, 32'h00084080);
      check("t2_pc", dis_pc, 32'h00400000);
      check("t2_src", dis_src, 1'b0);
      check("t2_seq", dis_seq, 16'd0);
      step();
      check("t2_idle", dis_valid, 1'b0);

      // 3: both ports push 3 entries each after a fresh reset
      rst = 1; step(); rst = 0;
      clear_log();
      for (int i = 0; i < 3; i++) begin
         in0_valid = 1; in0_inst = 32'h10000000 + i; in0_pc = 32'h00400000 + 4 * i;
         in1_valid = 1; in1_inst = 32'h20000000 + i; in1_pc = 32'h00500000 + 4 * i;
         step();
      end
      in0_valid = 0; in1_valid = 0;
      repeat (8) step();
      check("t3_count", log_inst.size(), 6);
      for (int i = 0; i < 3; i++) begin
         exp_inst[2 * i]     = 32'h10000000 + i;
         exp_inst[2 * i + 1] = 32'h20000000 + i;
      end
      if (log_inst.size() == 6) begin
         for (int i = 0; i < 6; i++) begin
            check("t3_src", log_src[i], i % 2);
            check("t3_seq", log_seq[i], i);
            check("t3_inst", log_inst[i], exp_inst[i]);
         end
      end

      // 4: stalled printer, port 1 pushes 5 entries into a 4-deep FIFO
      dis_ready = 0;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) check("t4_rdy_before_full", in1_ready, 1'b1);
         in1_valid = 1; in1_inst = 32'h30000000 + i; in1_pc = 32'h00600000 + 4 * i;
         step();
      end
      in1_valid = 0;
      check("t4_full", in1_ready, 1'b0);
      held = 32'h30000000;
      for (int i = 0; i < 10; i++) begin
         step();
         check("t4_hold_inst", dis_inst, held);
         check("t4_hold_seq", dis_seq, 16'd6);
         check("t4_hold_valid", dis_valid, 1'b1);
      end
      clear_log();
      dis_ready = 1;
      repeat (8) step();
      check("t4_count", log_inst.size(), 5);
      if (log_inst.size() == 5) begin
         for (int i = 0; i < 5; i++) begin
            check("t4_inst", log_inst[i], 32'h30000000 + i);
            check("t4_seq", log_seq[i], 6 + i);
         end
      end

      // 5: flush with one presented and two queued, plus a same-cycle push
      dis_ready = 0;
      for (int i = 0; i < 3; i++) begin
         in0_valid = 1; in0_inst = 32'h40000000 + i; in0_pc = 32'h00700000 + 4 * i;
         step();
      end
      check("t5_pre_valid", dis_valid, 1'b1);
      check("t5_pre_inst", dis_inst, 32'h40000000);
      check("t5_pre_seq", dis_seq, 16'd11);
      flush = 1; in0_inst = 32'h40000003;
      step();
      flush = 0; in0_valid = 0;
      check("t5_flushed", dis_valid, 1'b0);
      clear_log();
      dis_ready = 1;
      repeat (5) step();
      check("t5_nothing", log_inst.size(), 0);
      check("t5_still_idle", dis_valid, 1'b0);
      in0_valid = 1; in0_inst = 32'h50000000; in0_pc = 32'h00800000;
      step();
      in0_valid = 0;
      step();
      check("t5_post_valid", dis_valid, 1'b1);
      check("t5_post_inst", dis_inst, 32'h50000000);
      check("t5_post_seq", dis_seq, 16'd12);
      step();

      // 6: nop on port 0 alongside a real word on port 1
      rst = 1; step(); rst = 0;
      clear_log();
      in0_valid = 1; in0_inst = 32'h00000000; in0_pc = 32'h00400100;
      in1_valid = 1; in1_inst = 32'h25280005; in1_pc = 32'h00400104;
      step();
      in0_valid = 0; in1_valid = 0;
      repeat (4) step();
`ifdef TRACE_NOP_FILTER_EN
      check("t6_drop", drop_cnt, 16'd1);
      check("t6_count", log_inst.size(), 1);
      if (log_inst.size() == 1) begin
         check("t6_inst", log_inst[0], 32'h25280005);
         check("t6_seq", log_seq[0], 16'd0);
         check("t6_src", log_src[0], 1'b1);
      end
`else
      check("t6_drop", drop_cnt, 16'd0);
      check("t6_count", log_inst.size(), 2);
      if (log_inst.size() == 2) begin
         check("t6_nop_inst", log_inst[0], 32'h00000000);
         check("t6_nop_seq", log_seq[0], 16'd0);
         check("t6_inst", log_inst[1], 32'h25280005);
         check("t6_seq", log_seq[1], 16'd1);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/disasm_trace_sched.md
Name: disasm_trace_sched

Overview:
- Schedules instruction-trace traffic from two pipeline taps (port 0 = IF, port 1 = WB) onto the single shared BINARY_TO_MIPS disassembler.
- Each tap has its own FIFO. A round-robin arbiter drains the FIFOs into one registered presentation stage.
- The presentation stage drives the disassembler input and holds it stable until the trace printer accepts it.
- Sits beside the pipelined CPU in simulation/debug builds only; it has no effect on architectural state.

Parameters:
- DEPTH, 4, entries per tap FIFO. Power of two, ≥2.
- SEQ_W, 16, width of the issue sequence counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of both FIFOs and the presentation stage.
- in0_valid  in  1  IF tap offers an entry.
- in0_ready  out  1  IF FIFO can accept.
- in0_inst  in  32  IF instruction word.
- in0_pc  in  32  IF PC.
- in1_valid  in  1  WB tap offers an entry.
- in1_ready  out  1  WB FIFO can accept.
- in1_inst  in  32  WB instruction word.
- in1_pc  in  32  WB PC.
- dis_valid  out  1  presentation stage holds an entry.
- dis_ready  in  1  printer consumes the entry this cycle.
- dis_inst  out  32  word to the disassembler input.
- dis_pc  out  32  PC of the presented entry.
- dis_src  out  1  0 = IF, 1 = WB.
- dis_seq  out  SEQ_W  issue number of the presented entry.
- drop_cnt  out  16  entries rejected by the filter (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clock edge):
  - Both FIFOs empty.
  - dis_valid=0; dis_inst, dis_pc, dis_src, dis_seq all 0; drop_cnt=0.
  - Internal issue counter = 0.
  - last_grant=1, so port 0 wins the first tie.
  - in*_ready=1 from the cycle after reset.
  - rst has priority over every other input.
- Push: an entry is accepted when in*_valid && in*_ready.
  - in*_ready = !full, computed from the registered FIFO state only.
  - A full FIFO rejects a push even when it pops in the same cycle; there is no pass-through.
- Presentation stage states:
  - IDLE: dis_valid=0.
  - PRESENT: dis_valid=1.
- Load condition: load = (!dis_valid || dis_ready) && (FIFO0 non-empty || FIFO1 non-empty).
  - On load, the granted FIFO pops and its head is registered into dis_*.
  - dis_seq takes the issue counter value, then the counter increments, wrapping at 2^SEQ_W.
  - Transitions: IDLE→PRESENT on load. PRESENT→PRESENT on dis_ready && load (back-to-back, one entry per cycle). PRESENT→IDLE on dis_ready && !load.
- Hold: while PRESENT && !dis_ready, all dis_* outputs are held bit-stable.
- Arbitration:
  - Only one FIFO non-empty: grant it.
  - Both non-empty: grant !last_grant.
  - last_grant updates only on load.
- Latency: a push into an empty FIFO at edge N, with the stage free, gives dis_valid=1 after edge N+1. There is no bypass path.
- Ordering: per-port FIFO order is preserved; cross-port order follows the arbitration rules.
- Flush: at the edge, both FIFOs are emptied and dis_valid→0.
  - Pushes in the same cycle are discarded.
  - The issue counter and drop_cnt are NOT cleared.
  - last_grant is unchanged.
- FIFO pointers: width log2(DEPTH)+1; full/empty determined by MSB compare.

Optional Feature:
- Macro: TRACE_NOP_FILTER_EN.
- Defined:
  - A push whose inst == 32'h00000000 (nop) is accepted (ready semantics unchanged) but not stored.
  - drop_cnt increments by the number of such pushes this cycle (0, 1 or 2), saturating at 16'hFFFF.
  - Dropped entries do not consume an issue number.
- Undefined:
  - Nops are stored like any other word.
  - drop_cnt is tied to 0.

Test Plan:
1. rst high 2 cycles, then low, no traffic → dis_valid=0, all dis_* =0, in0_ready=in1_ready=1, drop_cnt=0.
2. Single push on port 0 (inst=32'h00084080, pc=32'h00400000) with dis_ready=1 → one cycle later dis_valid=1, dis_inst=32'h00084080, dis_src=0, dis_seq=0; next cycle dis_valid=0.
3. Both ports push 3 entries each simultaneously, dis_ready=1 → dis_src sequence 0,1,0,1,0,1; dis_seq 0..5 back-to-back; FIFO order intact within each port.
4. dis_ready=0 with port 1 pushing 5 entries (DEPTH=4) → the first entry moves to the presentation stage; in1_ready drops to 0 once 4 entries remain queued; dis_inst holds stable for 10 cycles; then dis_ready=1 drains the rest in order.
5. flush asserted with 2 entries queued and one presented, same-cycle push on port 0 → dis_valid=0 next cycle; nothing emerges afterward; dis_seq continues from its prior count on the next push.
6. TRACE_NOP_FILTER_EN defined, push 32'h00000000 on port 0 and 32'h25280005 on port 1 simultaneously → drop_cnt=1; only 32'h25280005 presented, with dis_seq=0.
